parking_space_manager: RTL

//  Upstream stage of park_space_number. Holds the per-space free bitmap
//  (1 = free) and drives it, with a lookup enable, into the combinational

---
 rtl/parking_space_manager_if.sv | 44 ++++
 rtl/parking_space_manager.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/parking_space_manager_if.sv
// Parking space manager bus: gate/allocator side (master) and manager side (slave).
// Optional statistics ports are present when PARK_STATS_EN is defined.
interface parking_space_manager_if;
  localparam int unsigned NUM_SPACES = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned IDX_W      = 3;

  logic                  car_enter;
  logic                  car_exit;
  logic [IDX_W-1:0]      exit_space;
  logic [IDX_W-1:0]      alloc_number;
  logic [NUM_SPACES-1:0] parking_capacity;
  logic                  alloc_enable;
  logic                  busy;
  logic                  grant;
  logic [IDX_W-1:0]      granted_space;
  logic                  reject;
  logic                  exit_error;
  logic [CNT_W-1:0]      free_count;
  logic                  full;
  logic                  empty;
`ifdef PARK_STATS_EN
  logic [15:0]           entry_total;
  logic [15:0]           reject_total;
`endif

  modport master (
    output car_enter, car_exit, exit_space, alloc_number,
    input  parking_capacity, alloc_enable, busy, grant, granted_space,
    input  reject, exit_error, free_count, full, empty
`ifdef PARK_STATS_EN
    , input entry_total, reject_total
`endif
  );

  modport slave (
    input  car_enter, car_exit, exit_space, alloc_number,
    output parking_capacity, alloc_enable, busy, grant, granted_space,
    output reject, exit_error, free_count, full, empty
`ifdef PARK_STATS_EN
    , output entry_total, reject_total
`endif
  );
endinterface

// File: rtl/parking_space_manager.sv
// Parking space manager: holds the free-space bitmap (1 = free), sequences
// entry requests through an IDLE/LOOKUP FSM against the external allocator,
// releases spaces on exit and reports free count / full / empty.
// Optional macro PARK_STATS_EN adds saturating grant/reject totals.
module parking_space_manager (
  input logic                    clk,
  input logic                    rst_n,
  parking_space_manager_if.slave bus
);
  localparam int unsigned NUM_SPACES = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned IDX_W      = 3;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOOKUP = 1'b1;

  logic [0:0]            state, state_nxt;
  logic [NUM_SPACES-1:0] capacity_q, capacity_nxt;
  logic [CNT_W-1:0]      free_count_q, free_count_nxt;
  logic                  full_q, empty_q;
  logic                  alloc_enable_q, alloc_enable_nxt;
  logic                  busy_q, busy_nxt;
  logic                  grant_q, grant_nxt;
  logic                  reject_q, reject_nxt;
  logic                  exit_error_q, exit_error_nxt;
  logic [IDX_W-1:0]      granted_space_q, granted_space_nxt;

  // Number of set bits in a bitmap; keeps the count tied to the bitmap itself.
  function automatic logic [CNT_W-1:0] count_free(input logic [NUM_SPACES-1:0] bm);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_SPACES; i++) begin
      n = n + CNT_W'(bm[i]);
    end
    return n;
  endfunction

  // Next state, next outputs and next bitmap (allocation commit plus exit release).
  always_comb begin
    state_nxt         = state;
    alloc_enable_nxt  = 1'b0;
    busy_nxt          = 1'b0;
    grant_nxt         = 1'b0;
    reject_nxt        = 1'b0;
    exit_error_nxt    = 1'b0;
    granted_space_nxt = granted_space_q;
    capacity_nxt      = capacity_q;

    case (state)
      ST_IDLE: begin
        if (bus.car_enter) begin
          state_nxt        = ST_LOOKUP;
          alloc_enable_nxt = 1'b1;
          busy_nxt         = 1'b1;
        end
      end
      ST_LOOKUP: begin
        state_nxt = ST_IDLE;
        if (capacity_q == '0) begin
          reject_nxt = 1'b1;
        end else begin
          grant_nxt                       = 1'b1;
          granted_space_nxt               = bus.alloc_number;
          capacity_nxt[bus.alloc_number] = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // An exit naming a free space (including the one being granted now) is an error.
    if (bus.car_exit) begin
      if (capacity_q[bus.exit_space]) begin
        exit_error_nxt = 1'b1;
      end else begin
        capacity_nxt[bus.exit_space] = 1'b1;
      end
    end

    free_count_nxt = count_free(capacity_nxt);
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      capacity_q      <= '1;
      free_count_q    <= CNT_W'(NUM_SPACES);
      full_q          <= 1'b0;
      empty_q         <= 1'b1;
      alloc_enable_q  <= 1'b0;
      busy_q          <= 1'b0;
      grant_q         <= 1'b0;
      reject_q        <= 1'b0;
      exit_error_q    <= 1'b0;
      granted_space_q <= '0;
    end else begin
      state           <= state_nxt;
      capacity_q      <= capacity_nxt;
      free_count_q    <= free_count_nxt;
      full_q          <= (free_count_nxt == '0);
      empty_q         <= (free_count_nxt == CNT_W'(NUM_SPACES));
      alloc_enable_q  <= alloc_enable_nxt;
      busy_q          <= busy_nxt;
      grant_q         <= grant_nxt;
      reject_q        <= reject_nxt;
      exit_error_q    <= exit_error_nxt;
      granted_space_q <= granted_space_nxt;
    end
  end

`ifdef PARK_STATS_EN
  logic [15:0] entry_total_q, reject_total_q;

  // Saturating grant/reject totals, updated on the edge that raises the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_total_q  <= '0;
      reject_total_q <= '0;
    end else begin
      if (grant_nxt && (entry_total_q != 16'hFFFF)) begin
        entry_total_q <= entry_total_q + 16'd1;
      end
      if (reject_nxt && (reject_total_q != 16'hFFFF)) begin
        reject_total_q <= reject_total_q + 16'd1;
      end
    end
  end

  assign bus.entry_total  = entry_total_q;
  assign bus.reject_total = reject_total_q;
`endif

  assign bus.parking_capacity = capacity_q;
  assign bus.free_count       = free_count_q;
  assign bus.full             = full_q;
  assign bus.empty            = empty_q;
  assign bus.alloc_enable     = alloc_enable_q;
  assign bus.busy             = busy_q;
  assign bus.grant            = grant_q;
  assign bus.reject           = reject_q;
  assign bus.exit_error       = exit_error_q;
  assign bus.granted_space    = granted_space_q;
endmodule
